vga_frame_rd_sched: RTL and testbench
=====================================

Name: vga_frame_rd_sched

Overview:
- Schedules DDR burst reads of one stored frame into the display-side pixel FIFO, one pass per displayed frame.
- Tracks which of two ping-pong frame banks was last completed by the write path.
- At each display frame start, it selects that bank, flushes the FIFO and issues bursts whenever the FIFO has room.
- Sits between the DDR read-port arbiter and the display FIFO, in the DDR user clock domain. frame_start arrives already synchronised.

Parameters:
ADDR_W, 28, DDR byte-address width
BEAT_BYTES, 8, bytes per DDR data beat
BURST_LEN, 64, maximum beats per read command
FRAME_BEATS, 122880, beats per frame (1280x768 bytes / 8)
FIFO_DEPTH, 512, display FIFO depth in beats
LVL_W, 10, width of FIFO level input (holds 0..FIFO_DEPTH)
BANK0_BASE, 28'h0000000, byte base address of bank 0
BANK1_BASE, 28'h0200000, byte base address of bank 1

Ports:
clk  in  1  DDR user clock; single clock domain
rst  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse: new display frame begins
wr_bank_done  in  1  one-cycle pulse: write path finished a full frame
wr_bank_idx  in  1  bank finished, valid with wr_bank_done
fifo_wr_cnt  in  LVL_W  current display FIFO fill level in beats
fifo_clr  out  1  one-cycle FIFO flush pulse
rd_req  out  1  read command valid
rd_addr  out  ADDR_W  read command byte address
rd_len  out  8  read command length in beats (1..BURST_LEN)
rd_ack  in  1  command accepted when rd_req && rd_ack
rd_data_vld  in  1  one returned beat, written to FIFO externally
rd_bank  out  1  bank being read this frame
frame_active  out  1  high while the current frame is still being fetched
frame_abort  out  1  one-cycle pulse: frame_start arrived before fetch complete
abort_cnt  out  8  saturating count of aborts

Behaviour:
- Reset: all outputs 0; state IDLE; ready_vld=0; ready_bank=0; offsets/counters 0. Reset mid-burst discards outstanding beats (the DDR side is reset with it).
- Bank tracking: wr_bank_done sets ready_bank<=wr_bank_idx and ready_vld<=1. If it coincides with frame_start, the new index is used for that frame (bypass).
- States: IDLE, FILL, REQ, DATA, DONE.
- IDLE/DONE on frame_start:
  - If ready_vld (or bypass): rd_bank<=bank; offset<=0; beats_left<=FRAME_BEATS; fifo_clr=1 for 1 cycle; frame_active<=1; go to FILL.
  - Otherwise stay; no reads.
- FILL:
  - If beats_left==0: frame_active<=0, go to DONE.
  - Else compute space=FIFO_DEPTH-fifo_wr_cnt in LVL_W+1 bits and len=min(BURST_LEN,beats_left).
  - If space>=len: go to REQ.
  - FILL is never left in the cycle immediately after fifo_clr; one settle cycle is required.
- REQ:
  - rd_req=1; rd_addr=base(rd_bank)+offset; rd_len=len. All three are held stable until the handshake.
  - On rd_req&&rd_ack: rd_req<=0, beat_cnt<=len, go to DATA.
- DATA:
  - Each rd_data_vld decrements beat_cnt.
  - On the last beat: offset+=len*BEAT_BYTES; beats_left-=len; go to FILL.
  - Beats arriving outside DATA are ignored.
- Only one command is outstanding. FIFO space is re-evaluated only in FILL, so it never overflows.
- frame_start while frame_active:
  - Always: frame_abort=1 for 1 cycle; abort_cnt+=1, saturating at 255.
  - In FILL or REQ (not yet acked): drop rd_req next cycle and restart immediately, exactly as from IDLE.
  - In REQ with rd_ack in the same cycle as frame_start: the command counts as accepted; go to DATA with restart_pending.
  - In DATA: set restart_pending, drain the remaining beats, then restart (fifo_clr, new bank, offset 0) instead of returning to FILL.
- Final burst length equals beats_left when beats_left<BURST_LEN. FRAME_BEATS need not be a multiple of BURST_LEN.
- Address arithmetic is modulo 2^ADDR_W. Bank bases plus frame size never overlap (integration guarantee).

Test Plan:
1. Reset, then wr_bank_done idx=1, then frame_start with fifo_wr_cnt=0 -> fifo_clr pulse; first rd_req with rd_addr=0x0200000, rd_len=64, rd_bank=1.
2. Hold rd_ack low 5 cycles -> rd_req, rd_addr, rd_len stable throughout; accepted only on ack; 64 rd_data_vld beats -> next rd_addr=0x0200200.
3. fifo_wr_cnt=460 (space 52<64) -> no rd_req; drop to 448 -> rd_req issued.
4. FRAME_BEATS=100, BURST_LEN=64 -> commands of len 64 then 36; frame_active falls after the 100th beat; state DONE.
5. frame_start during DATA with 10 beats left -> frame_abort pulse, abort_cnt=1, 10 beats drained, then fifo_clr and rd_addr back to the bank base.
6. wr_bank_done idx=0 coincident with frame_start while reading bank 1 in DONE -> new frame reads BANK0_BASE, rd_bank=0.

Source files
------------

// File: rtl/vga_frame_rd_sched_if.sv
// DDR read-port command/response bundle between the frame read scheduler and the arbiter.
// rd_req/rd_addr/rd_len stay stable until rd_req && rd_ack; rd_data_vld marks one returned beat.
interface vga_frame_rd_sched_if #(
    parameter int ADDR_W = 28
) ();
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack;
    logic              rd_data_vld;

    modport master (
        output rd_req, rd_addr, rd_len,
        input  rd_ack, rd_data_vld
    );

    modport slave (
        input  rd_req, rd_addr, rd_len,
        output rd_ack, rd_data_vld
    );
endinterface

// File: rtl/vga_frame_rd_sched.sv
// Fetches one ping-pong frame bank per display frame into the pixel FIFO as DDR bursts,
// issuing a burst only when the FIFO has room for all of it.
module vga_frame_rd_sched #(
    parameter int                ADDR_W      = 28,
    parameter int                BEAT_BYTES  = 8,
    parameter int                BURST_LEN   = 64,
    parameter int                FRAME_BEATS = 122880,
    parameter int                FIFO_DEPTH  = 512,
    parameter int                LVL_W       = 10,
    parameter logic [ADDR_W-1:0] BANK0_BASE  = 28'h0000000,
    parameter logic [ADDR_W-1:0] BANK1_BASE  = 28'h0200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             wr_bank_done,
    input  logic             wr_bank_idx,
    input  logic [LVL_W-1:0] fifo_wr_cnt,
    output logic             fifo_clr,
    vga_frame_rd_sched_if.master rd,
    output logic             rd_bank,
    output logic             frame_active,
    output logic             frame_abort,
    output logic [7:0]       abort_cnt,
    output logic [2:0]       fsm_state
);
    localparam int BL_W = $clog2(FRAME_BEATS + 1);

    typedef enum logic [2:0] {IDLE, FILL, REQ, DATA, DONE} state_t;

    state_t            state;
    logic              ready_vld;
    logic              ready_bank;
    logic              restart_pending;
    logic [1:0]        settle;
    logic [ADDR_W-1:0] offset;
    logic [BL_W-1:0]   beats_left;
    logic [7:0]        beat_cnt;

    logic              last_beat;
    logic              start_req;
    logic              start_ok;
    logic              start_bank;
    logic [7:0]        len_c;
    logic [LVL_W:0]    space_c;

    assign fsm_state = state;

    always_comb begin
        last_beat  = (state == DATA) && rd.rd_data_vld && (beat_cnt == 8'd1);
        start_ok   = wr_bank_done | ready_vld;
        start_bank = wr_bank_done ? wr_bank_idx : ready_bank;
        // An ack coinciding with frame_start commits the burst, so that case drains via DATA.
        start_req  = (frame_start && ((state == IDLE) || (state == DONE) || (state == FILL) ||
                                      ((state == REQ) && !rd.rd_ack))) ||
                     (last_beat && (restart_pending || frame_start));
        len_c      = (beats_left < BL_W'(BURST_LEN)) ? beats_left[7:0] : 8'(BURST_LEN);
        space_c    = (LVL_W+1)'(FIFO_DEPTH) - {1'b0, fifo_wr_cnt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ready_vld       <= 1'b0;
            ready_bank      <= 1'b0;
            restart_pending <= 1'b0;
            settle          <= 2'd0;
            offset          <= '0;
            beats_left      <= '0;
            beat_cnt        <= 8'd0;
            fifo_clr        <= 1'b0;
            rd.rd_req       <= 1'b0;
            rd.rd_addr      <= '0;
            rd.rd_len       <= 8'd0;
            rd_bank         <= 1'b0;
            frame_active    <= 1'b0;
            frame_abort     <= 1'b0;
            abort_cnt       <= 8'd0;
        end else begin
            fifo_clr    <= 1'b0;
            frame_abort <= 1'b0;

            if (wr_bank_done) begin
                ready_bank <= wr_bank_idx;
                ready_vld  <= 1'b1;
            end

            if (frame_start && frame_active) begin
                frame_abort <= 1'b1;
                if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
            end

            if (start_req) begin
                rd.rd_req       <= 1'b0;
                restart_pending <= 1'b0;
                if (start_ok) begin
                    rd_bank      <= start_bank;
                    offset       <= '0;
                    beats_left   <= BL_W'(FRAME_BEATS);
                    fifo_clr     <= 1'b1;
                    frame_active <= 1'b1;
                    settle       <= 2'd2;
                    state        <= FILL;
                end else begin
                    frame_active <= 1'b0;
                    state        <= IDLE;
                end
            end else begin
                case (state)
                    FILL: begin
                        // Two idle cycles let the FIFO level reflect the flush before it is trusted.
                        if (settle != 2'd0) begin
                            settle <= settle - 2'd1;
                        end else if (beats_left == '0) begin
                            frame_active <= 1'b0;
                            state        <= DONE;
                        end else if (space_c >= (LVL_W+1)'(len_c)) begin
                            rd.rd_req  <= 1'b1;
                            rd.rd_addr <= (rd_bank ? BANK1_BASE : BANK0_BASE) + offset;
                            rd.rd_len  <= len_c;
                            state      <= REQ;
                        end
                    end
                    REQ: begin
                        if (rd.rd_ack) begin
                            rd.rd_req <= 1'b0;
                            beat_cnt  <= rd.rd_len;
                            if (frame_start) restart_pending <= 1'b1;
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        if (frame_start) restart_pending <= 1'b1;
                        if (rd.rd_data_vld) begin
                            beat_cnt <= beat_cnt - 8'd1;
                            if (beat_cnt == 8'd1) begin
                                offset     <= offset + ADDR_W'(rd.rd_len) * ADDR_W'(BEAT_BYTES);
                                beats_left <= beats_left - BL_W'(rd.rd_len);
                                state      <= FILL;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_rd_sched.sv
// Directed bench for the frame read scheduler using a 100-beat frame (bursts of 64 then 36).
module tb_vga_frame_rd_sched;
    localparam int ADDR_W = 28;
    localparam int LVL_W  = 10;
    localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_REQ = 3'd2, S_DATA = 3'd3, S_DONE = 3'd4;

    logic             clk, rst;
    logic             frame_start, wr_bank_done, wr_bank_idx;
    logic [LVL_W-1:0] fifo_wr_cnt;
    logic             fifo_clr, rd_bank, frame_active, frame_abort;
    logic [7:0]       abort_cnt;
    logic [2:0]       fsm_state;
    int               checks, errors;

    vga_frame_rd_sched_if #(.ADDR_W(ADDR_W)) rd ();

    vga_frame_rd_sched #(.FRAME_BEATS(100)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .wr_bank_done(wr_bank_done),
        .wr_bank_idx(wr_bank_idx), .fifo_wr_cnt(fifo_wr_cnt), .fifo_clr(fifo_clr), .rd(rd),
        .rd_bank(rd_bank), .frame_active(frame_active), .frame_abort(frame_abort),
        .abort_cnt(abort_cnt), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic deliver(input int n);
        for (int i = 0; i < n; i++) begin
            rd.rd_data_vld = 1'b1;
            step();
        end
        rd.rd_data_vld = 1'b0;
    endtask

    task automatic ack_cmd();
        rd.rd_ack = 1'b1;
        step();
        rd.rd_ack = 1'b0;
    endtask

    task automatic wait_req(input int budget, input logic [ADDR_W-1:0] exp_addr, input logic [7:0] exp_len);
        int n = 0;
        while (rd.rd_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (rd.rd_req !== 1'b1) begin
            errors++;
            $display("FAIL wait_req: rd_req=%b after %0d cycles, required 1", rd.rd_req, n);
        end
        checks++;
        if (rd.rd_addr !== exp_addr || rd.rd_len !== exp_len) begin
            errors++;
            $display("FAIL req_cmd: addr=%h len=%0d, required addr=%h len=%0d", rd.rd_addr, rd.rd_len, exp_addr, exp_len);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if ({fifo_clr, rd.rd_req, rd.rd_addr, rd.rd_len, rd_bank, frame_active, frame_abort, abort_cnt} !== '0 || fsm_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: clr=%b req=%b addr=%h len=%0d bank=%b act=%b abort=%b cnt=%0d st=%0d, required all 0",
                     fifo_clr, rd.rd_req, rd.rd_addr, rd.rd_len, rd_bank, frame_active, frame_abort, abort_cnt, fsm_state);
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        checks++;
        if (fifo_clr !== 1'b0 || fsm_state !== S_IDLE || frame_active !== 1'b0) begin
            errors++;
            $display("FAIL no_bank_start: clr=%b st=%0d act=%b, required 0/IDLE/0", fifo_clr, fsm_state, frame_active);
        end
    endtask

    task automatic test_first_req();
        wr_bank_done = 1'b1;
        wr_bank_idx  = 1'b1;
        step();
        wr_bank_done = 1'b0;
        frame_start  = 1'b1;
        step();
        frame_start  = 1'b0;
        checks++;
        if (fifo_clr !== 1'b1 || rd_bank !== 1'b1 || frame_active !== 1'b1 || frame_abort !== 1'b0 || fsm_state !== S_FILL) begin
            errors++;
            $display("FAIL start_bank1: clr=%b bank=%b act=%b abort=%b st=%0d, required 1/1/1/0/FILL",
                     fifo_clr, rd_bank, frame_active, frame_abort, fsm_state);
        end
        step();
        checks++;
        if (fifo_clr !== 1'b0 || rd.rd_req !== 1'b0) begin
            errors++;
            $display("FAIL clr_pulse: clr=%b req=%b, required 0/0", fifo_clr, rd.rd_req);
        end
        step();
        checks++;
        if (rd.rd_req !== 1'b0) begin
            errors++;
            $display("FAIL settle: rd_req=%b, required 0", rd.rd_req);
        end
        wait_req(10, 28'h0200000, 8'd64);
    endtask

    task automatic test_hold_ack();
        int seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (rd.rd_req !== 1'b1 || rd.rd_addr !== 28'h0200000 || rd.rd_len !== 8'd64) begin
                errors++;
                $display("FAIL hold_stable: cyc %0d req=%b addr=%h len=%0d, required 1/0200000/64", i, rd.rd_req, rd.rd_addr, rd.rd_len);
            end
        end
        ack_cmd();
        checks++;
        if (rd.rd_req !== 1'b0 || fsm_state !== S_DATA) begin
            errors++;
            $display("FAIL ack_accept: req=%b st=%0d, required 0/DATA", rd.rd_req, fsm_state);
        end
        fifo_wr_cnt = 10'd480;
        deliver(64);
        checks++;
        if (fsm_state !== S_FILL) begin
            errors++;
            $display("FAIL burst_done: st=%0d, required FILL", fsm_state);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (rd.rd_req === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL space_32: rd_req seen %0d cycles, required 0", seen);
        end
        fifo_wr_cnt = 10'd476;
        wait_req(5, 28'h0200200, 8'd36);
    endtask

    task automatic test_frame_end();
        ack_cmd();
        fifo_wr_cnt = 10'd0;
        deliver(35);
        checks++;
        if (frame_active !== 1'b1 || fsm_state !== S_DATA) begin
            errors++;
            $display("FAIL beat99: act=%b st=%0d, required 1/DATA", frame_active, fsm_state);
        end
        deliver(1);
        step();
        checks++;
        if (frame_active !== 1'b0 || fsm_state !== S_DONE || rd.rd_req !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: act=%b st=%0d req=%b, required 0/DONE/0", frame_active, fsm_state, rd.rd_req);
        end
    endtask

    task automatic test_fifo_space();
        int seen = 0;
        fifo_wr_cnt = 10'd460;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        checks++;
        if (fifo_clr !== 1'b1 || frame_abort !== 1'b0 || abort_cnt !== 8'd0 || rd_bank !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: clr=%b abort=%b cnt=%0d bank=%b, required 1/0/0/1", fifo_clr, frame_abort, abort_cnt, rd_bank);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd.rd_req === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL space_52: rd_req seen %0d cycles, required 0", seen);
        end
        fifo_wr_cnt = 10'd448;
        wait_req(5, 28'h0200000, 8'd64);
    endtask

    task automatic test_abort_data();
        fifo_wr_cnt = 10'd0;
        ack_cmd();
        deliver(64);
        wait_req(5, 28'h0200200, 8'd36);
        ack_cmd();
        deliver(26);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        checks++;
        if (frame_abort !== 1'b1 || abort_cnt !== 8'd1 || fsm_state !== S_DATA || fifo_clr !== 1'b0) begin
            errors++;
            $display("FAIL abort_data: abort=%b cnt=%0d st=%0d clr=%b, required 1/1/DATA/0", frame_abort, abort_cnt, fsm_state, fifo_clr);
        end
        step();
        checks++;
        if (frame_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: abort=%b, required 0", frame_abort);
        end
        deliver(9);
        checks++;
        if (fifo_clr !== 1'b0 || fsm_state !== S_DATA) begin
            errors++;
            $display("FAIL drain9: clr=%b st=%0d, required 0/DATA", fifo_clr, fsm_state);
        end
        deliver(1);
        checks++;
        if (fifo_clr !== 1'b1 || fsm_state !== S_FILL || rd_bank !== 1'b1 || frame_active !== 1'b1) begin
            errors++;
            $display("FAIL drain_restart: clr=%b st=%0d bank=%b act=%b, required 1/FILL/1/1", fifo_clr, fsm_state, rd_bank, frame_active);
        end
        wait_req(10, 28'h0200000, 8'd64);
    endtask

    task automatic test_abort_req();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        checks++;
        if (frame_abort !== 1'b1 || abort_cnt !== 8'd2 || rd.rd_req !== 1'b0 || fifo_clr !== 1'b1 || fsm_state !== S_FILL) begin
            errors++;
            $display("FAIL abort_req: abort=%b cnt=%0d req=%b clr=%b st=%0d, required 1/2/0/1/FILL",
                     frame_abort, abort_cnt, rd.rd_req, fifo_clr, fsm_state);
        end
        wait_req(10, 28'h0200000, 8'd64);
    endtask

    task automatic test_bank_switch();
        ack_cmd();
        deliver(64);
        wait_req(5, 28'h0200200, 8'd36);
        ack_cmd();
        deliver(36);
        step();
        checks++;
        if (fsm_state !== S_DONE || frame_active !== 1'b0) begin
            errors++;
            $display("FAIL bank1_done: st=%0d act=%b, required DONE/0", fsm_state, frame_active);
        end
        frame_start  = 1'b1;
        wr_bank_done = 1'b1;
        wr_bank_idx  = 1'b0;
        step();
        frame_start  = 1'b0;
        wr_bank_done = 1'b0;
        checks++;
        if (rd_bank !== 1'b0 || fifo_clr !== 1'b1 || frame_abort !== 1'b0 || abort_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bypass_bank: bank=%b clr=%b abort=%b cnt=%0d, required 0/1/0/2", rd_bank, fifo_clr, frame_abort, abort_cnt);
        end
        wait_req(10, 28'h0000000, 8'd64);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        frame_start = 1'b0;
        wr_bank_done = 1'b0;
        wr_bank_idx = 1'b0;
        fifo_wr_cnt = '0;
        rd.rd_ack = 1'b0;
        rd.rd_data_vld = 1'b0;
        test_reset();
        test_first_req();
        test_hold_ack();
        test_frame_end();
        test_fifo_space();
        test_abort_data();
        test_abort_req();
        test_bank_switch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
